stage_phase_accumulator: RTL and testbench

STAGE_PHASE_ACCUMULATOR -- requirements
Module: stage_phase_accumulator

---
 rtl/stage_phase_accumulator_pkg.sv | 36 +++
 rtl/stage_phase_accumulator.sv | 129 ++++++++++++
 tb/tb_stage_phase_accumulator.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_phase_accumulator_pkg.sv
// Shared constants, ID helpers and mode encoding for the stage phase accumulator.
// Operator IDs are {voice, operator}; 32 voices x 8 operators = 256 slots.
package stage_phase_accumulator_pkg;

  localparam int unsigned DEFAULT_NUM_VOICES  = 32;
  localparam int unsigned OPERATORS_PER_VOICE = 8;
  localparam int unsigned OP_ID_WIDTH         = 3;
  localparam int unsigned VOICE_ID_WIDTH      = 5;
  localparam int unsigned NUM_VOICE_OPERATORS = DEFAULT_NUM_VOICES * OPERATORS_PER_VOICE;
  localparam int unsigned VOICE_OPERATOR_ID   = VOICE_ID_WIDTH + OP_ID_WIDTH;
  localparam int unsigned PHASE_ACC_WIDTH     = 24;
  localparam int unsigned PHASE_WIDTH         = 16;
  localparam int unsigned STEP_LOW_WIDTH      = 16;
  localparam int unsigned STEP_HIGH_WIDTH     = PHASE_ACC_WIDTH - STEP_LOW_WIDTH;

  typedef logic [VOICE_OPERATOR_ID-1:0] voice_operator_id_t;
  typedef logic [VOICE_ID_WIDTH-1:0]    voice_id_t;
  typedef logic [OP_ID_WIDTH-1:0]       op_id_t;
  typedef logic [PHASE_ACC_WIDTH-1:0]   phase_acc_t;

  // Sweep clears every slot once after reset before normal accumulation starts.
  typedef enum logic {
    MODE_SWEEP = 1'b0,
    MODE_RUN   = 1'b1
  } mode_t;

  function automatic voice_id_t getVoiceID(input voice_operator_id_t id);
    return voice_id_t'(id >> OP_ID_WIDTH);
  endfunction

  function automatic voice_operator_id_t makeVoiceOperatorID(input voice_id_t voice,
                                                              input op_id_t op);
    return {voice, op};
  endfunction

endpackage

// File: rtl/stage_phase_accumulator.sv
// Time-multiplexed 24-bit phase accumulator: one operator per cycle, two-cycle latency.
// Optional macro SYNC_PHASE_ON_NOTE_ON_EN restarts phase on a voice note-on rising edge.
module stage_phase_accumulator
  import stage_phase_accumulator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = DEFAULT_NUM_VOICES
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_PhaseStepLowWriteEnable,
  input  logic                         i_PhaseStepHighWriteEnable,
  input  logic                         i_NoteOnWriteEnable,
  input  logic [VOICE_OPERATOR_ID-1:0] i_ConfigWriteAddr,
  input  logic [15:0]                  i_ConfigWriteData,
  output logic [PHASE_WIDTH-1:0]       o_Phase,
  output logic                         o_NoteOn,
  output logic [VOICE_OPERATOR_ID-1:0] o_VoiceOperator
);

  voice_operator_id_t count;
  mode_t              mode;

  phase_acc_t                 acc_mem     [NUM_VOICE_OPERATORS];
  logic [STEP_LOW_WIDTH-1:0]  step_lo_mem [NUM_VOICE_OPERATORS];
  logic [STEP_HIGH_WIDTH-1:0] step_hi_mem [NUM_VOICE_OPERATORS];
  logic [NUM_VOICES-1:0]      note_on;

  phase_acc_t         acc_r;
  phase_acc_t         step_r;
  logic               note_r;
  logic               sweep_r;
  voice_operator_id_t id_r;
  phase_acc_t         next_acc;
  phase_acc_t         wb_acc;

  // Slot counter and init-sweep mode; the sweep ends after slot 255 is read.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count <= '0;
      mode  <= MODE_SWEEP;
    end else begin
      count <= count + voice_operator_id_t'(1);
      if (mode == MODE_SWEEP && count == '1) begin
        mode <= MODE_RUN;
      end
    end
  end

  // Step halves are separate RAMs so simultaneous low/high writes both land.
  always_ff @(posedge i_Clock) begin
    if (i_PhaseStepLowWriteEnable) begin
      step_lo_mem[i_ConfigWriteAddr] <= i_ConfigWriteData;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_PhaseStepHighWriteEnable) begin
      step_hi_mem[i_ConfigWriteAddr] <= i_ConfigWriteData[STEP_HIGH_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      note_on <= '0;
    end else if (i_NoteOnWriteEnable) begin
      note_on[getVoiceID(i_ConfigWriteAddr)] <= i_ConfigWriteData[0];
    end
  end

  // Read stage: registered reads see pre-write contents of a same-cycle config write.
  always_ff @(posedge i_Clock) begin
    acc_r  <= acc_mem[count];
    step_r <= {step_hi_mem[count], step_lo_mem[count]};
    note_r <= note_on[getVoiceID(count)];
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sweep_r <= 1'b1;
      id_r    <= '0;
    end else begin
      sweep_r <= (mode == MODE_SWEEP);
      id_r    <= count;
    end
  end

`ifdef SYNC_PHASE_ON_NOTE_ON_EN
  logic prev_mem [NUM_VOICE_OPERATORS];
  logic prev_r;

  always_ff @(posedge i_Clock) begin
    prev_r <= prev_mem[count];
  end

  always_ff @(posedge i_Clock) begin
    prev_mem[id_r] <= sweep_r ? 1'b0 : note_r;
  end

  always_comb begin
    next_acc = acc_r + step_r;
    if (note_r && !prev_r) begin
      next_acc = step_r;
    end
  end
`else
  always_comb begin
    next_acc = acc_r + step_r;
  end
`endif

  assign wb_acc = sweep_r ? '0 : next_acc;

  always_ff @(posedge i_Clock) begin
    acc_mem[id_r] <= wb_acc;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Phase         <= '0;
      o_NoteOn        <= 1'b0;
      o_VoiceOperator <= '0;
    end else begin
      o_Phase         <= wb_acc[PHASE_ACC_WIDTH-1 -: PHASE_WIDTH];
      o_NoteOn        <= note_r & ~sweep_r;
      o_VoiceOperator <= id_r;
    end
  end

endmodule

// File: tb/tb_stage_phase_accumulator.sv
// Self-checking bench for stage_phase_accumulator: random config traffic against a
// slot-level reference model, plus directed wrap, latency, hazard and reset checks.
module tb_stage_phase_accumulator;
  import stage_phase_accumulator_pkg::*;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_PhaseStepLowWriteEnable;
  logic        i_PhaseStepHighWriteEnable;
  logic        i_NoteOnWriteEnable;
  logic [7:0]  i_ConfigWriteAddr;
  logic [15:0] i_ConfigWriteData;
  logic [15:0] o_Phase;
  logic        o_NoteOn;
  logic [7:0]  o_VoiceOperator;

  always #5 i_Clock = ~i_Clock;

  stage_phase_accumulator #(.NUM_VOICES(32)) dut (
    .i_Clock                    (i_Clock),
    .i_Reset                    (i_Reset),
    .i_PhaseStepLowWriteEnable  (i_PhaseStepLowWriteEnable),
    .i_PhaseStepHighWriteEnable (i_PhaseStepHighWriteEnable),
    .i_NoteOnWriteEnable        (i_NoteOnWriteEnable),
    .i_ConfigWriteAddr          (i_ConfigWriteAddr),
    .i_ConfigWriteData          (i_ConfigWriteData),
    .o_Phase                    (o_Phase),
    .o_NoteOn                   (o_NoteOn),
    .o_VoiceOperator            (o_VoiceOperator)
  );

  typedef struct {
    int unsigned phase;
    bit          note;
    int unsigned id;
  } out_t;

  int unsigned m_acc   [256];
  int unsigned m_step  [256];
  bit          m_prev  [256];
  bit          m_note  [32];
  int unsigned m_count;
  int unsigned m_sweep_left;
  out_t        exp_now;
  out_t        exp_pending;
  bit          rand_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One slot visit as seen from the outside: phase = (old + step) mod 2^24, or cleared in the sweep.
  function automatic out_t visit(input int unsigned c);
    out_t        r;
    int unsigned v;
    v = c / 8;
    r.id = c;
    if (m_sweep_left > 0) begin
      m_sweep_left--;
      m_acc[c]  = 0;
      m_prev[c] = 1'b0;
      r.phase   = 0;
      r.note    = 1'b0;
    end else begin
      m_acc[c] = (m_acc[c] + m_step[c]) % (1 << 24);
`ifdef SYNC_PHASE_ON_NOTE_ON_EN
      if (m_note[v] && !m_prev[c]) m_acc[c] = m_step[c];
      m_prev[c] = m_note[v];
`endif
      r.phase = m_acc[c] / 256;
      r.note  = m_note[v];
    end
    return r;
  endfunction

  task automatic model_edge();
    int unsigned a;
    a = i_ConfigWriteAddr;
    if (i_Reset) begin
      exp_now      = '{0, 1'b0, 0};
      exp_pending  = '{0, 1'b0, 0};
      m_count      = 0;
      m_sweep_left = 256;
      foreach (m_note[v]) m_note[v] = 1'b0;
    end else begin
      exp_now     = exp_pending;
      exp_pending = visit(m_count);
      m_count     = (m_count + 1) % 256;
      if (i_NoteOnWriteEnable) m_note[a / 8] = i_ConfigWriteData[0];
    end
    if (i_PhaseStepLowWriteEnable)
      m_step[a] = (m_step[a] & 32'hFF0000) | i_ConfigWriteData;
    if (i_PhaseStepHighWriteEnable)
      m_step[a] = (m_step[a] & 32'h00FFFF) | ((i_ConfigWriteData & 32'hFF) << 16);
  endtask

  task automatic drive_random();
    int unsigned r;
    i_PhaseStepLowWriteEnable  = 1'b0;
    i_PhaseStepHighWriteEnable = 1'b0;
    i_NoteOnWriteEnable        = 1'b0;
    if (rand_en) begin
      r = $urandom_range(7, 0);
      i_ConfigWriteData = 16'($urandom);
      if (r <= 1) begin
        i_ConfigWriteAddr          = 8'($urandom_range(255, 8'h40));
        i_PhaseStepLowWriteEnable  = ($urandom_range(1, 0) == 1);
        i_PhaseStepHighWriteEnable = ($urandom_range(1, 0) == 1);
      end else if (r == 2) begin
        i_ConfigWriteAddr   = makeVoiceOperatorID(5'($urandom_range(31, 8)), 3'($urandom));
        i_NoteOnWriteEnable = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    model_edge();
    #1;
    chk("phase",   32'(o_Phase),         exp_now.phase);
    chk("note_on", 32'(o_NoteOn),        32'(exp_now.note));
    chk("op_id",   32'(o_VoiceOperator), exp_now.id);
    drive_random();
  endtask

  task automatic wait_id(input logic [7:0] id);
    int unsigned n;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_VoiceOperator !== id && n < 600);
    chk("wait_id", 32'(o_VoiceOperator), 32'(id));
  endtask

  // Reset has just been released: 257 edges of zero phase/note-on.
  task automatic sweep_check();
    for (int k = 0; k < 257; k++) begin
      tick();
      chk("sweep_phase", 32'(o_Phase), 32'h0);
      chk("sweep_note",  32'(o_NoteOn), 32'h0);
    end
  endtask

  task automatic write_step(input logic [7:0] a, input logic [23:0] v);
    i_ConfigWriteAddr         = a;
    i_ConfigWriteData         = v[15:0];
    i_PhaseStepLowWriteEnable = 1'b1;
    tick();
    i_ConfigWriteAddr          = a;
    i_ConfigWriteData          = {8'h00, v[23:16]};
    i_PhaseStepHighWriteEnable = 1'b1;
    tick();
  endtask

  initial begin
    int unsigned n;
    i_Reset                    = 1'b1;
    i_PhaseStepLowWriteEnable  = 1'b0;
    i_PhaseStepHighWriteEnable = 1'b0;
    i_NoteOnWriteEnable        = 1'b0;
    i_ConfigWriteAddr          = '0;
    i_ConfigWriteData          = '0;
    foreach (m_acc[i]) begin
      m_acc[i] = 0; m_step[i] = 0; m_prev[i] = 1'b0;
    end
    m_count = 0; m_sweep_left = 256;
    exp_now = '{0, 1'b0, 0}; exp_pending = '{0, 1'b0, 0};

    tick();
    chk("reset_phase", 32'(o_Phase), 32'h0);
    chk("reset_op_id", 32'(o_VoiceOperator), 32'h0);

    // Load every step under reset with combined low+high writes.
    for (int i = 0; i < 256; i++) begin
      i_ConfigWriteAddr          = 8'(i);
      i_ConfigWriteData          = 16'($urandom);
      i_PhaseStepLowWriteEnable  = 1'b1;
      i_PhaseStepHighWriteEnable = 1'b1;
      tick();
    end
    write_step(8'h00, 24'h000100);
    write_step(8'h10, 24'h000200);
    for (int i = 8'h18; i < 8'h20; i++) write_step(8'(i), 24'h400000);
    write_step(8'h20, 24'hFFFF00);

    i_Reset = 1'b0;
    rand_en = 1'b1;
    sweep_check();

    // Pass 1
    wait_id(8'h00); chk("step100_p1", 32'(o_Phase), 32'h0001);
    wait_id(8'h10); chk("id10_p1",    32'(o_Phase), 32'h0002);
    wait_id(8'h18); chk("v3_p1",      32'(o_Phase), 32'h4000);
    chk("v3_note_p1", 32'(o_NoteOn), 32'h0);
    wait_id(8'h20); chk("wrap_p1",    32'(o_Phase), 32'hFFFF);
    wait_id(8'h40);
    i_PhaseStepLowWriteEnable  = 1'b0;
    i_PhaseStepHighWriteEnable = 1'b0;
    i_ConfigWriteAddr          = makeVoiceOperatorID(5'd3, 3'd0);
    i_ConfigWriteData          = 16'h0001;
    i_NoteOnWriteEnable        = 1'b1;
    wait_id(8'hFF);
    tick(); chk("op_id_wrap", 32'(o_VoiceOperator), 32'h00);
    chk("step100_p2", 32'(o_Phase), 32'h0002);

    // Pass 2: step write to 0x10 lands in the same cycle 0x10 is read.
    wait_id(8'h0E);
    i_NoteOnWriteEnable        = 1'b0;
    i_PhaseStepHighWriteEnable = 1'b0;
    i_ConfigWriteAddr          = 8'h10;
    i_ConfigWriteData          = 16'h0800;
    i_PhaseStepLowWriteEnable  = 1'b1;
    wait_id(8'h10); chk("id10_old_step", 32'(o_Phase), 32'h0004);
    wait_id(8'h18);
`ifdef SYNC_PHASE_ON_NOTE_ON_EN
    chk("v3_sync_p2", 32'(o_Phase), 32'h4000);
`else
    chk("v3_free_p2", 32'(o_Phase), 32'h8000);
`endif
    chk("v3_note_p2", 32'(o_NoteOn), 32'h1);
    wait_id(8'h20); chk("wrap_p2", 32'(o_Phase), 32'hFFFE);

    // Pass 3
    wait_id(8'h00); chk("step100_p3",    32'(o_Phase), 32'h0003);
    wait_id(8'h10); chk("id10_new_step", 32'(o_Phase), 32'h000C);
    wait_id(8'h18);
`ifdef SYNC_PHASE_ON_NOTE_ON_EN
    chk("v3_sync_p3", 32'(o_Phase), 32'h8000);
`else
    chk("v3_free_p3", 32'(o_Phase), 32'hC000);
`endif

    // Counter value appears on o_VoiceOperator two edges later.
    n = 0;
    while (m_count != 5 && n < 300) begin
      tick();
      n++;
    end
    tick(); tick();
    chk("latency2", 32'(o_VoiceOperator), 32'h05);

    // Mid-run reset with the counter at 0x80.
    wait_id(8'h7E);
    i_Reset = 1'b1;
    tick();
    chk("midreset_phase", 32'(o_Phase), 32'h0);
    i_Reset = 1'b0;
    sweep_check();
    wait_id(8'h00); chk("restart_id0", 32'(o_Phase), 32'h0001);
    wait_id(8'h18); chk("restart_v3",  32'(o_Phase), 32'h4000);
    chk("restart_v3_note", 32'(o_NoteOn), 32'h0);

    for (int k = 0; k < 300; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
